// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
//   one result bit per clock, using a single full-subtractor cell and a
//   registered borrow. Lives beside the serial adder in the lab ALU.
//
//   Operation: start in IDLE latches a/b, then WIDTH RUN cycles produce one
//   difference bit each, then a one-cycle DONE state pulses done and returns
//   to IDLE. Throughput is one operation per WIDTH+2 cycles.
//
// Ports
//   clk             in   1      rising-edge clock
//   rst_n           in   1      asynchronous active-low reset
//   start           in   1      request; honoured only in IDLE
//   a               in   WIDTH  minuend, sampled on the accepting edge
//   b               in   WIDTH  subtrahend, sampled on the accepting edge
//   busy            out  1      high while in RUN
//   done            out  1      one-cycle pulse when diff/borrow update
//   diff            out  WIDTH  a - b mod 2^WIDTH, held until next completion
//   borrow          out  1      borrow out of the MSB (a < b), held with diff
//   diff_bit        out  1      serial difference bit, LSB first
//   diff_bit_valid  out  1      diff_bit carries a fresh result bit
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             diff_bit,
   output logic             diff_bit_valid
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             br_q, br_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbit_q, dbit_d;
   logic             dbv_q, dbv_d;

   // Full-subtractor cell on the current LSBs of the operand shift registers.
   logic           ai, bi, d_bit, br_nxt;
   logic [WIDTH:0] res_ext;

   always_comb begin
      ai      = a_sh_q[0];
      bi      = b_sh_q[0];
      d_bit   = ai ^ bi ^ br_q;
      br_nxt  = (~ai & bi) | (~(ai ^ bi) & br_q);
      // New bit enters at the MSB; after WIDTH shifts the LSB lands at bit 0.
      res_ext = {d_bit, res_q};
   end

   // Next-state and datapath update.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      done_d   = 1'b0;
      dbit_d   = dbit_q;
      dbv_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               br_d    = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = res_ext[WIDTH:1];
            br_d   = br_nxt;
            cnt_d  = cnt_q + CNT_W'(1);
            dbit_d = d_bit;
            dbv_d  = 1'b1;
            if (cnt_q == LAST_CNT) begin
               diff_d   = res_ext[WIDTH:1];
               borrow_d = br_nxt;
               done_d   = 1'b1;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbit_q   <= 1'b0;
         dbv_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbit_q   <= dbit_d;
         dbv_q    <= dbv_d;
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign diff           = diff_q;
   assign borrow         = borrow_q;
   assign diff_bit       = dbit_q;
   assign diff_bit_valid = dbv_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1. Stimulus
//   pushes the arithmetic reference result per accepted operation; monitors
//   pop and compare on each done pulse.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int unsigned W  = 8;
   localparam int unsigned W1 = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          start8, busy8, done8, borrow8, dbit8, dbv8;
   logic [W-1:0]  a8, b8, diff8;
   logic          start1, busy1, done1, borrow1, dbit1, dbv1;
   logic [W1-1:0] a1, b1, diff1;

   serial_subtractor #(.WIDTH(W)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8),
      .diff_bit(dbit8), .diff_bit_valid(dbv8)
   );

   serial_subtractor #(.WIDTH(W1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1),
      .diff_bit(dbit1), .diff_bit_valid(dbv1)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic burst = 1'b0;

   logic [W:0]  q8[$];   // {borrow, diff}
   logic [W1:0] q1[$];

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // Reference: plain unsigned arithmetic.
   function automatic logic [W:0] ref8(logic [W-1:0] x, logic [W-1:0] y);
      logic [W-1:0] dv;
      dv = W'(int'(x) - int'(y));
      return {(x < y), dv};
   endfunction

   function automatic logic [W1:0] ref1(logic [W1-1:0] x, logic [W1-1:0] y);
      logic [W1-1:0] dv;
      dv = W1'(int'(x) - int'(y));
      return {(x < y), dv};
   endfunction

   // Monitor for the WIDTH=8 instance.
   initial begin : mon8
      logic [W-1:0] bits;
      logic [W:0]   e;
      int           nbits, busy_cnt, last_done_cyc;
      logic [W-1:0] last_diff;
      logic         last_borrow, prev_done;
      bits = '0; nbits = 0; busy_cnt = 0; last_done_cyc = -1;
      last_diff = '0; last_borrow = 1'b0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            bits = '0; nbits = 0; busy_cnt = 0;
            last_diff = '0; last_borrow = 1'b0; prev_done = 1'b0;
         end else begin
            if (dbv8) begin
               if (nbits < int'(W)) bits = bits | (W'(dbit8) << nbits);
               nbits++;
            end
            if (busy8) busy_cnt++;
            if (busy8 && !done8) begin
               chk("held_diff", 32'(diff8), 32'(last_diff));
               chk("held_borrow", 32'(borrow8), 32'(last_borrow));
            end
            if (done8) begin
               chk("done_one_cycle", 32'(prev_done), 32'(0));
               if (q8.size() == 0) begin
                  chk("unexpected_done", 32'(1), 32'(0));
               end else begin
                  e = q8.pop_front();
                  chk("diff", 32'(diff8), 32'(e[W-1:0]));
                  chk("borrow", 32'(borrow8), 32'(e[W]));
                  chk("serial_bits", 32'(bits), 32'(e[W-1:0]));
                  chk("serial_count", 32'(nbits), 32'(W));
                  chk("busy_cycles", 32'(busy_cnt), 32'(W));
                  last_diff = e[W-1:0];
                  last_borrow = e[W];
               end
               if (burst && last_done_cyc >= 0)
                  chk("burst_spacing", 32'(cyc - last_done_cyc), 32'(W + 2));
               last_done_cyc = burst ? cyc : -1;
               bits = '0; nbits = 0; busy_cnt = 0;
            end
            prev_done = done8;
         end
      end
   end

   // Monitor for the WIDTH=1 instance.
   initial begin : mon1
      logic [W1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && done1) begin
            if (q1.size() == 0) begin
               chk("w1_unexpected_done", 32'(1), 32'(0));
            end else begin
               e = q1.pop_front();
               chk("w1_diff", 32'(diff1), 32'(e[W1-1:0]));
               chk("w1_borrow", 32'(borrow1), 32'(e[W1]));
               chk("w1_bit", 32'(dbit1), 32'(e[W1-1:0]));
               chk("w1_bit_valid", 32'(dbv1), 32'(1));
            end
         end
      end
   end

   task automatic wait8();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (q8.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("timeout_w8", 32'(q8.size()), 32'(0));
         q8.delete();
      end
   endtask

   task automatic wait1();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (q1.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         chk("timeout_w1", 32'(q1.size()), 32'(0));
         q1.delete();
      end
   endtask

   task automatic op8(logic [W-1:0] x, logic [W-1:0] y);
      wait8();
      @(posedge clk); #1;
      start8 = 1'b1; a8 = x; b8 = y;
      q8.push_back(ref8(x, y));
      @(posedge clk); #1;
      start8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom);
   endtask

   task automatic op1(logic [W1-1:0] x, logic [W1-1:0] y);
      wait1();
      @(posedge clk); #1;
      start1 = 1'b1; a1 = x; b1 = y;
      q1.push_back(ref1(x, y));
      @(posedge clk); #1;
      start1 = 1'b0; a1 = ~x; b1 = ~y;
   endtask

   initial begin : stim
      start8 = 1'b0; a8 = '0; b8 = '0;
      start1 = 1'b0; a1 = '0; b1 = '0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy8), 32'(0));
      chk("rst_done", 32'(done8), 32'(0));
      chk("rst_diff", 32'(diff8), 32'(0));
      chk("rst_borrow", 32'(borrow8), 32'(0));
      chk("rst_dbit", 32'(dbit8), 32'(0));
      chk("rst_dbv", 32'(dbv8), 32'(0));
      chk("rst_w1_diff", 32'(diff1), 32'(0));
      rst_n = 1'b1;

      // Directed operands including the borrow and equal cases.
      op8(8'h5A, 8'h3C);
      op8(8'h00, 8'h01);
      op8(8'h80, 8'h80);
      op8(8'hFF, 8'h00);

      // start during RUN must be ignored.
      op8(8'h10, 8'h01);
      repeat (2) @(posedge clk);
      #1 start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
      @(posedge clk); #1 start8 = 1'b0;
      wait8();

      // start held high with operands changing every cycle.
      @(posedge clk); #1;
      burst = 1'b1;
      for (int i = 0; i < 4 * int'(W + 2); i++) begin
         start8 = 1'b1; a8 = W'($urandom); b8 = W'($urandom);
         if (i % int'(W + 2) == 0) q8.push_back(ref8(a8, b8));
         @(posedge clk); #1;
      end
      start8 = 1'b0;
      wait8();
      burst = 1'b0;

      // Random operations.
      for (int i = 0; i < 20; i++) op8(W'($urandom), W'($urandom));

      // Reset in the middle of RUN aborts without a done pulse.
      op8(8'h77, 8'h11);
      wait8();
      @(posedge clk); #1;
      start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
      @(posedge clk); #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy8), 32'(0));
      chk("midrst_done", 32'(done8), 32'(0));
      chk("midrst_diff", 32'(diff8), 32'(0));
      chk("midrst_borrow", 32'(borrow8), 32'(0));
      chk("midrst_dbit", 32'(dbit8), 32'(0));
      chk("midrst_dbv", 32'(dbv8), 32'(0));
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      op8(8'h03, 8'h05);
      wait8();

      // WIDTH=1 instance: all operand combinations.
      op1(1'b0, 1'b0);
      op1(1'b1, 1'b0);
      op1(1'b0, 1'b1);
      op1(1'b1, 1'b1);
      wait1();

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
